// File: rtl/apb_slave_regs.sv
// APB register-bank slave with a configurable wait-state counter.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are full-word read/write.

`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

module apb_slave_regs #(
  parameter int unsigned                  NUM_REGS    = 8,
  parameter int unsigned                  WAIT_STATES = 1,
  parameter int unsigned                  REG_AW      = 8,
  parameter logic [`APB_DATA_WIDTH-1:0]   ID_VALUE    = 32'h0A9B_0001
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic                        psel_x,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [`PADDR_WIDTH-1:0]     paddr,
  input  logic [`APB_DATA_WIDTH-1:0]  pwdata,
  output logic [`APB_DATA_WIDTH-1:0]  prdata_x,
  output logic                        pready_x,
  output logic                        pslverr_x
);

  localparam int unsigned DW = `APB_DATA_WIDTH;
  localparam int unsigned AW = `PADDR_WIDTH;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] a_q, a_d;
  logic              w_q, w_d;
  logic [DW-1:0]     d_q, d_d;
  logic              wr_en;

  logic [DW-1:0]     regs_q [1:NUM_REGS-1];
  logic [DW-1:0]     rd_reg;
  logic [31:0]       idx_ext;
  logic              err;

  // Only the register window is decoded; the bridge has already decoded psel_x.
  generate
    if (AW > REG_AW) begin : g_unused_paddr
      logic unused_paddr;
      assign unused_paddr = ^paddr[AW-1:REG_AW];
    end
  endgenerate

  assign idx_ext = 32'(a_q[REG_AW-1:2]);
  assign err     = (a_q[1:0] != 2'b00) || (idx_ext >= NUM_REGS) || (w_q && (idx_ext == 32'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    w_d     = w_q;
    d_d     = d_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel_x && !penable) begin
          a_d     = paddr[REG_AW-1:0];
          w_d     = pwrite;
          d_d     = pwdata;
          cnt_d   = WaitInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!psel_x || !penable) begin
          // Master abandoned the transfer: no commit, no response.
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wr_en   = w_q && !err;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      w_q     <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      w_q     <= w_d;
      d_q     <= d_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (idx_ext == i) begin
          regs_q[i] <= d_q;
        end
      end
    end
  end

  always_comb begin
    rd_reg = '0;
    if (idx_ext == 32'd0) begin
      rd_reg = ID_VALUE;
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (idx_ext == i) begin
        rd_reg = regs_q[i];
      end
    end
  end

  // Responses depend only on registered state, never directly on bus inputs.
  assign pready_x  = (state_q == StAccess) && (cnt_q == 4'd0);
  assign prdata_x  = (pready_x && !w_q && !err) ? rd_reg : '0;
  assign pslverr_x = pready_x && err;

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB responder at the far end of the AHB-to-APB bridge: a slave_x register bank with a configurable wait-state counter.
- Decodes the APB setup and access phases and commits writes. Returns read data.
- Drives pready_x/pslverr_x back into the bridge. Serves as the reference APB slave for the bridge bench and as a template for peripheral register blocks.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; index 0 is a read-only ID register.
- WAIT_STATES, 1, access-phase cycles with pready_x low before completion (0..15).
- REG_AW, 8, byte-offset window width decoded from paddr; upper paddr bits are ignored (bridge decodes psel_x).
- ID_VALUE, 32'h0A9B_0001, constant returned by register 0.

Ports:
- hclk  input  1  system clock; the APB side runs on hclk.
- hreset  input  1  synchronous, active-high reset.
- psel_x  input  1  APB select for this slave.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  `PADDR_WIDTH  APB byte address.
- pwdata  input  `APB_DATA_WIDTH  APB write data.
- prdata_x  output  `APB_DATA_WIDTH  read data, valid only while pready_x=1.
- pready_x  output  1  transfer complete.
- pslverr_x  output  1  error response, valid only while pready_x=1.

Behaviour:
- Clock and reset: one clock, hclk. hreset is synchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0.
  - pready_x=0, pslverr_x=0, prdata_x=0.
  - Registers 1..NUM_REGS-1 = 0. Register 0 is always ID_VALUE.
  - Reset asserted mid-transfer aborts it: no write commit; the next transfer starts from a clean IDLE.
- FSM state IDLE:
  - On psel_x=1 and penable=0 (setup phase), capture paddr, pwrite and pwdata into a_q, w_q and d_q.
  - Load cnt=WAIT_STATES and go to ACCESS.
  - All other input combinations are ignored.
- FSM state ACCESS:
  - If psel_x=0 or penable=0 (protocol abort), return to IDLE with no commit and no response.
  - Else if cnt!=0, decrement cnt.
  - Else (cnt==0) this is the completion cycle. pready_x=1; a write commits at this clock edge; next state is IDLE.
- Outputs are decoded from registered state only (no input-to-output combinational path):
  - pready_x = (state==ACCESS) and (cnt==0).
  - prdata_x = selected register when pready_x=1 and the access is a non-error read; 0 otherwise.
  - pslverr_x = err when pready_x=1; 0 otherwise.
- Latency: the setup cycle plus WAIT_STATES+1 access cycles. WAIT_STATES=0 completes in the first access cycle.
- Back-to-back transfers: after the completion cycle the FSM is in IDLE, so a setup phase in the very next cycle is accepted with no bubble.
- Address decode:
  - off = a_q[REG_AW-1:0], idx = off[REG_AW-1:2].
  - err = (off[1:0]!=0) or (idx>=NUM_REGS) or (w_q and idx==0).
- Error handling:
  - Errored writes leave all registers unchanged.
  - Errored reads return prdata_x=0.
  - Error responses use the same wait-state timing as normal transfers.
- Captured values are stable: a_q, w_q and d_q hold for the whole transfer, and changes to paddr/pwdata during ACCESS are ignored.
- Width rules: registers are `APB_DATA_WIDTH wide, and pwdata is written whole (no strobes). cnt is 4 bits.

Test Plan:
- Reset, then read idx0 (paddr=0x00), WAIT_STATES=1 -> pready_x low in access cycle 1, high in cycle 2 with prdata_x=32'h0A9B_0001 and pslverr_x=0.
- Write 0xDEAD_BEEF to 0x04, then read 0x04 back-to-back -> write completes with pslverr_x=0; the read's setup is accepted in the next cycle and returns 0xDEAD_BEEF. Repeat with WAIT_STATES=0 to confirm single-cycle access.
- Error cases:
  - Write to 0x00 -> pslverr_x=1 on completion, and a subsequent read still returns ID_VALUE.
  - Read 0x20 (idx 8) -> pslverr_x=1, prdata_x=0.
  - Read 0x06 (misaligned) -> pslverr_x=1.
- Drop psel_x in the first access cycle of a write to 0x08 with pwdata=0x1234 -> pready_x never asserts and a later read of 0x08 returns 0.
- Assert hreset in the access cycle of a write to 0x0C (pwdata=0x55) -> all outputs 0 the next cycle, register 0x0C stays 0, and a fresh read afterwards completes normally.
- Change paddr to 0x10 during ACCESS of a read of 0x04 holding 0xDEAD_BEEF -> response still returns 0xDEAD_BEEF.
